// File: rtl/qbert_pio_pkg.sv
// qbert_pio_pkg: register offsets, edge-type codes and debounce counter sizing shared by the button PIO
package qbert_pio_pkg;
    localparam logic [1:0] PIO_DATA    = 2'd0;
    localparam logic [1:0] PIO_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_EDGECAP = 2'd3;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;
    function automatic int cnt_width(input int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction
endpackage

// File: rtl/qbert_button_debounce.sv
// qbert_button_debounce: one-bit two-flop synchroniser followed by a stability counter driving db
module qbert_button_debounce
    import qbert_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic db
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    logic s1, s2;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            if (s2 == db) cnt <= '0;
            else if (cnt == CNT_MAX) begin
                db  <= s2;
                cnt <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/qbert_button_pio_irq.sv
// qbert_button_pio_irq: Avalon-MM button input PIO with per-bit debounce, edge capture and maskable level irq
module qbert_button_pio_irq
    import qbert_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic [WIDTH-1:0] db, db_d, edge_det, edge_r, mask, edgecap, clr;
    logic wr, unused_wd;
    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_bit
        qbert_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk),
            .reset(reset),
            .pin(in_port[i]),
            .db(db[i])
        );
    end
    assign edge_det = (EDGE_TYPE == EDGE_RISE) ? (db & ~db_d) :
                      (EDGE_TYPE == EDGE_FALL) ? (~db & db_d) : (db ^ db_d);
    assign wr = chipselect && !write_n;
    assign clr = (wr && address == PIO_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    assign irq = |(edgecap & mask);
    assign unused_wd = ^writedata;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_d     <= '0;
            edge_r   <= '0;
            mask     <= '0;
            edgecap  <= '0;
            readdata <= '0;
        end else begin
            db_d   <= db;
            edge_r <= edge_det;
            if (wr && address == PIO_IRQMASK) mask <= writedata[WIDTH-1:0];
            // a fresh edge is ORed in after the clear so set wins over a same-cycle RW1C write
            edgecap  <= (edgecap & ~clr) | edge_r;
            readdata <= (address == PIO_DATA)    ? 32'(db) :
                        (address == PIO_IRQMASK) ? 32'(mask) :
                        (address == PIO_EDGECAP) ? 32'(edgecap) : 32'd0;
        end
    end
endmodule

// File: doc/qbert_button_pio_irq.md
# qbert_button_pio_irq

Parametrised Avalon-MM input PIO for the Q*bert board buttons. Successor to the single-bit polled button port: it adds a configurable input width, per-bit synchronisation and debounce, edge capture and a maskable interrupt. The NIOS CPU reads it on the system interconnect, so button presses no longer depend on polling timing.

## Interface
Parameters:
- `WIDTH`, default 4: number of button inputs, 1..32.
- `DEBOUNCE_CYCLES`, default 50000: clock cycles an input must stay stable before the debounced value follows it. Minimum 1.
- `EDGE_TYPE`, default 0: captured edge. 0 = rising, 1 = falling, 2 = any.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `address` in 2: Avalon word address.
- `chipselect` in 1: Avalon slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: registered read data.
- `in_port` in WIDTH: raw, asynchronous button pins.
- `irq` out 1: level interrupt to the CPU.

## Operation
- Per-bit input chain:
  - Two-flop synchroniser `s1` → `s2`.
  - Debounce counter `cnt` is sized for `DEBOUNCE_CYCLES`.
  - Each cycle: if `s2 == db`, then `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`, then `db <= s2` and `cnt <= 0`.
  - Else `cnt <= cnt+1`.
  - Any bounce back to `db` restarts the count.
- Edge detect: `db_d <= db`.
  - Rising edge = `db & ~db_d`.
  - Falling edge = `~db & db_d`.
  - Any edge = `db ^ db_d`, selected by `EDGE_TYPE`.
- Register map (word addresses):
  - 0 DATA (RO): `{0, db}`. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQMASK (RW): `mask[WIDTH-1:0]`.
  - 3 EDGECAPTURE (RW1C): writing 1 to a bit clears it. Writing 0 leaves it unchanged.
- Write occurs when `chipselect && !write_n`. Bits above `WIDTH` are ignored on write and read as 0.
- Capture: `edgecap[i] <= 1` in the cycle after edge i is detected.
- Simultaneous capture and clear on the same bit and cycle: set wins, so the bit stays 1.
- `irq = |(edgecap & mask)`, combinational from registers with no further latch.
- Reads have no side effects, including reads of EDGECAPTURE.

## Timing
- Reset values:
  - `readdata` = 0.
  - `irq` = 0.
  - `mask` = 0.
  - `edgecap` = 0.
  - `s1`, `s2`, `db`, `db_d` = 0.
  - `cnt` = 0.
- Read latency is 1 cycle. `readdata` is registered from the address presented in cycle N and is valid in cycle N+1. It updates every cycle regardless of `chipselect`.
- Write to `mask` or `edgecap` takes effect at the next edge, so `irq` reflects it 1 cycle after the write cycle.
- Pin change to `db`: 2 synchroniser cycles plus `DEBOUNCE_CYCLES` stable cycles.
- `db` change to `edgecap` set: 2 cycles (`db_d` compare, then capture).
- `irq` asserts in the same cycle `edgecap` sets, when masked in.
- Reset mid-count discards the pending transition. After release, the debounced value re-converges to a held input.
- With `DEBOUNCE_CYCLES` = 1, `db` follows `s2` one cycle after `s2` differs. There is no filtering.

## Structure
- Shared package `qbert_pio_pkg`:
  - Register offsets `PIO_DATA` = 0, `PIO_IRQMASK` = 2, `PIO_EDGECAP` = 3.
  - Edge-type constants `EDGE_RISE`, `EDGE_FALL`, `EDGE_ANY`.
  - A counter-width function (clog2 of `DEBOUNCE_CYCLES`, minimum 1).
- Sub-module `qbert_button_debounce`: one bit containing synchroniser, counter and `db`. It is instantiated `WIDTH` times via generate.
- The top level holds edge detect, registers, read mux and `irq`.

## Test plan
Bench parameters: `WIDTH` = 4, `DEBOUNCE_CYCLES` = 4, `EDGE_TYPE` = 0 unless stated.
- Reset then read addr 0, 2, 3 → all return 0 with 1-cycle latency. `irq` = 0.
- Hold `in_port` = 4'b0101 for 10 cycles → DATA reads 0x5. `db` changes exactly 6 cycles after the pin edge. `edgecap` = 0x5 two cycles later. `irq` stays 0 because mask = 0.
- Toggle `in_port[1]` 1 → 0 → 1 with 2-cycle pulses (shorter than 4) → `db[1]` never changes and `edgecap[1]` stays 0.
- Write mask = 0x1 with `edgecap` = 0x5 → `irq` = 1 the next cycle. Write 0x1 to addr 3 → `edgecap` = 0x4 and `irq` = 0 the next cycle.
- Write 0x8 to addr 3 in the same cycle `edgecap[3]` sets → `edgecap[3]` = 1 because set wins.
- `EDGE_TYPE` = 2, press and release bit 2 → `edgecap[2]` sets on the press. Clear it, then release sets it again. Assert `reset` mid-debounce → all registers return to 0 immediately.
